// File: rtl/pio_output_shift_register_if.sv
// PIO output shift register request bus.
// Carries instruction requests and the TX FIFO pop handshake.
interface pio_output_shift_register_if;
  logic        op_valid;
  logic        op_isPull;
  logic        op_block;
  logic [4:0]  op_bitCount;
  logic [31:0] op_xValue;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        stall;

  modport master (
    output op_valid, op_isPull, op_block,
    output op_bitCount, op_xValue,
    output tx_valid, tx_data,
    input  tx_ready, stall
  );

  modport slave (
    input  op_valid, op_isPull, op_block,
    input  op_bitCount, op_xValue,
    input  tx_valid, tx_data,
    output tx_ready, stall
  );
endinterface

// File: rtl/pio_output_shift_register.sv
// PIO output shift register: TX FIFO words in,
// OUT bit groups to the pin block out.
module pio_output_shift_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_shiftRight,
  input  logic                   cfg_autopull,
  input  logic [4:0]             cfg_pullThresh,
  pio_output_shift_register_if.slave bus,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   write_enable,
  output logic [COUNT_WIDTH-1:0] shiftCount
);

  localparam logic [COUNT_WIDTH-1:0] FULL =
    COUNT_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]  shiftReg;
  logic [COUNT_WIDTH-1:0] count;

  logic [COUNT_WIDTH-1:0] bitNum;
  logic [COUNT_WIDTH-1:0] threshNum;
  logic                   needRefill;
  logic                   stallNow;
  logic                   pullAccept;
  logic                   outAccept;
  logic                   refill;

  logic [DATA_WIDTH:0]    lowMask;
  logic [DATA_WIDTH-1:0]  outData;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [COUNT_WIDTH:0]   countSum;
  logic [COUNT_WIDTH-1:0] countNext;

  assign bitNum = (bus.op_bitCount == 5'd0)
    ? FULL : COUNT_WIDTH'(bus.op_bitCount);
  assign threshNum = (cfg_pullThresh == 5'd0)
    ? FULL : COUNT_WIDTH'(cfg_pullThresh);

  assign needRefill = cfg_autopull
    && (count >= threshNum);

  // Stall decision and FIFO pop arbitration; an
  // explicit PULL takes priority over background refill.
  always_comb begin
    stallNow   = 1'b0;
    pullAccept = 1'b0;
    outAccept  = 1'b0;
    refill     = 1'b0;
    if (!reset) begin
      if (bus.op_valid) begin
        if (bus.op_isPull)
          stallNow = !bus.tx_valid && bus.op_block;
        else
          stallNow = needRefill;
      end
      pullAccept = bus.op_valid && bus.op_isPull
        && !stallNow;
      outAccept = bus.op_valid && !bus.op_isPull
        && !stallNow;
      refill = needRefill && bus.tx_valid
        && !pullAccept;
    end
  end

  assign bus.stall = stallNow;
  assign bus.tx_ready = (pullAccept && bus.tx_valid)
    || refill;

  // Extract the outgoing bit group and the residue.
  always_comb begin
    lowMask = ((DATA_WIDTH+1)'(1) << bitNum)
      - (DATA_WIDTH+1)'(1);
    if (cfg_shiftRight) begin
      outData = shiftReg & lowMask[DATA_WIDTH-1:0];
      shifted = shiftReg >> bitNum;
    end else begin
      outData = shiftReg >> (FULL - bitNum);
      shifted = shiftReg << bitNum;
    end
  end

  // Consumed-bit counter saturates at a full word.
  always_comb begin
    countSum = {1'b0, count} + {1'b0, bitNum};
    if (countSum > {1'b0, FULL})
      countNext = FULL;
    else
      countNext = countSum[COUNT_WIDTH-1:0];
  end

  // Register state; loads reset the consumed count.
  always_ff @(posedge clock) begin
    if (reset) begin
      shiftReg     <= '0;
      count        <= FULL;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= outAccept;
      unique case (1'b1)
        outAccept: begin
          write_data <= outData;
          shiftReg   <= shifted;
          count      <= countNext;
        end
        pullAccept: begin
          shiftReg <= bus.tx_valid
            ? bus.tx_data : bus.op_xValue;
          count    <= '0;
        end
        refill: begin
          shiftReg <= bus.tx_data;
          count    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign shiftCount = count;

endmodule

// File: doc/pio_output_shift_register.md
Name: pio_output_shift_register

Overview:
Output Shift Register (OSR) for one PIO state machine. It sits between the TX FIFO and the pin block. It accepts words from the TX FIFO via explicit PULL or autopull, and shifts them out N bits at a time on OUT instructions. It drives the pin block's write_data/write_enable pair.

Parameters:
DATA_WIDTH, 32, shift register and FIFO word width; only 32 is supported.
COUNT_WIDTH, 6, width of the shift counter; must hold values 0..32.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cfg_shiftRight  input  1  1 = shift out LSBs first (right shift); 0 = shift out MSBs first (left shift)
cfg_autopull  input  1  enable automatic refill from TX FIFO
cfg_pullThresh  input  5  autopull threshold in bits; 0 encodes 32
op_valid  input  1  instruction request this cycle
op_isPull  input  1  1 = PULL, 0 = OUT
op_block  input  1  PULL only: 1 = stall while the FIFO is empty
op_bitCount  input  5  OUT only: bit count; 0 encodes 32
op_xValue  input  32  X scratch register value, loaded by a non-blocking PULL on an empty FIFO
tx_valid  input  1  TX FIFO not empty
tx_data  input  32  TX FIFO head word
tx_ready  output  1  pop the TX FIFO this cycle (combinational)
stall  output  1  op_valid is not accepted this cycle (combinational)
write_data  output  32  shifted-out bits, right-aligned and zero-extended (registered)
write_enable  output  1  one-cycle pulse qualifying write_data (registered)
shiftCount  output  6  bits consumed since the last load, 0..32 (registered)

Behaviour:
- State: shiftReg[31:0] and count[5:0]. Reset values: shiftReg=0, count=32 (OSR empty), write_data=0, write_enable=0. tx_ready=0 and stall=0 while reset is high.
- n = op_bitCount, with 0 treated as 32. thr = cfg_pullThresh, with 0 treated as 32.
- Accept rule: an op is accepted iff op_valid && !stall. stall is a combinational function of the current state, op fields and tx_valid.
- needRefill = cfg_autopull && (count >= thr).
- OUT:
  - stall = needRefill. Autopull refill happens before shifting.
  - When accepted, right-shift mode: data = shiftReg[n-1:0]; shiftReg <= shiftReg >> n.
  - When accepted, left-shift mode: data = shiftReg[31:32-n]; shiftReg <= shiftReg << n.
  - Vacated bits are zero filled. A shift by 32 yields 0.
  - count <= min(32, count+n). The add is 7 bits wide, then saturated.
  - write_data <= data, right-aligned and zero-extended. write_enable <= 1 on the next edge, so latency is 1 cycle.
- PULL:
  - If tx_valid: tx_ready=1, shiftReg <= tx_data, count <= 0, accepted.
  - If !tx_valid and op_block: stall=1, no state change.
  - If !tx_valid and !op_block: accepted, shiftReg <= op_xValue, count <= 0, tx_ready=0.
  - PULL never asserts write_enable.
- Background autopull refill:
  - Fires in any cycle where needRefill && tx_valid && !(accepted PULL).
  - Effect: tx_ready=1, shiftReg <= tx_data, count <= 0.
  - At most one FIFO pop per cycle. An explicit PULL wins over the background refill.
- OUT with needRefill and tx_valid: the refill happens this cycle and stall=1. The OUT is accepted next cycle from the fresh word, so the cost is 1 stall cycle.
- OUT with needRefill and !tx_valid: stall=1 every cycle until tx_valid rises.
- With cfg_autopull=0, OUT never stalls. OUT on an empty OSR (count=32) shifts out zeros and count stays 32.
- write_enable is low in every cycle that does not follow an accepted OUT. write_data holds its last value.
- Config inputs are sampled every cycle. Changing cfg_pullThresh mid-word takes effect in the same cycle.
- Reset asserted mid-operation: the next state is the reset state unconditionally. No FIFO pop occurs in that cycle.

Test Plan:
- Reset, then idle 3 cycles -> shiftCount=32, write_enable=0, write_data=0, tx_ready=0.
- cfg_autopull=0, right shift. PULL with tx_data=0xDEADBEEF, then OUT 8 -> tx_ready=1 on the PULL cycle. One cycle after the OUT: write_data=0x000000EF, write_enable=1, shiftCount=8.
- Left shift. Load 0xDEADBEEF, then OUT 4, OUT 4 -> write_data 0xD then 0xE. shiftCount 4 then 8.
- cfg_autopull=1, thr=8, FIFO holds 0x11223344 then 0xAABBCCDD, right shift. OUT 8 at count=32 -> 1 stall cycle with refill. Then 0x44. Next OUT 8 -> stall plus refill from the second word, then 0xDD.
- Blocking PULL with tx_valid=0 for 5 cycles -> stall=1 for 5 cycles, then accepted the cycle tx_valid rises. Non-blocking PULL on empty FIFO with op_xValue=0x00001234, then OUT 16 -> write_data=0x1234.
- Load 0xCAFEF00D, OUT with op_bitCount=0 -> write_data=0xCAFEF00D, shiftCount=32. Assert reset during a stalled blocking PULL -> shiftCount=32, stall=0 after release.
